// File: rtl/tooth_period_div.sv
// tooth_period_div: measures the clk-cycle period between tooth capture
// strobes and divides it by a sub-step count using an external integer_div.
// Publishes the quotient and remainder with a one-cycle valid strobe.
module tooth_period_div #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] subdiv,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divider,
  input  logic             div_rdy,
  input  logic [WIDTH-1:0] div_result,
  input  logic [WIDTH-1:0] div_rem,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             valid,
  output logic             ovf,
  output logic             overrun,
  output logic             dz
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_armed;
  logic [WIDTH-1:0] r_per;
  logic [WIDTH-1:0] r_divr;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_div_start;
  logic             r_valid;
  logic             r_ovf;
  logic             r_overrun;
  logic             r_dz;

  logic             w_cnt_sat;
  logic             w_sub_zero;
  logic             w_busy;

  assign w_cnt_sat  = (r_cnt == ALL_ONES);
  assign w_sub_zero = (subdiv == '0);
  assign w_busy     = (r_state == S_LOAD) || (r_state == S_RUN);

  // Period counter: restarts at 1 on each capture, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (cap) begin
      r_cnt <= WIDTH'(1);
    end else if (!w_cnt_sat) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  // Control FSM: operand latching, integer_div handshake and result publishing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_per       <= '0;
      r_divr      <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_div_start <= 1'b0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
      r_overrun   <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_dz      <= 1'b0;
      if (cap) begin
        if (!r_armed) begin
          // First capture only opens the measurement window.
          r_armed <= 1'b1;
        end else begin
          r_per       <= r_cnt;
          r_divr      <= subdiv;
          r_ovf       <= w_cnt_sat;
          r_div_start <= 1'b0;
          if (w_busy) begin
            r_overrun <= 1'b1;
          end
          if (w_sub_zero) begin
            // Division by zero is skipped and reported as a saturated quotient.
            r_quot  <= ALL_ONES;
            r_rem   <= '0;
            r_dz    <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_LOAD;
          end
        end
      end else begin
        case (r_state)
          S_LOAD: begin
            // integer_div has seen start low for one cycle; let it run.
            r_div_start <= 1'b1;
            r_state     <= S_RUN;
          end
          S_RUN: begin
            if (div_rdy) begin
              r_quot      <= div_result;
              r_rem       <= div_rem;
              r_valid     <= 1'b1;
              r_div_start <= 1'b0;
              r_state     <= S_DONE;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_div_start <= 1'b0;
            r_state     <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign div_start    = r_div_start;
  assign div_dividend = r_per;
  assign div_divider  = r_divr;
  assign quot         = r_quot;
  assign rem          = r_rem;
  assign valid        = r_valid;
  assign ovf          = r_ovf;
  assign overrun      = r_overrun;
  assign dz           = r_dz;

endmodule

// File: tb/tb_tooth_period_div.sv
// Bench for tooth_period_div: behavioural integer_div models, directed
// period/divisor table plus hand-written overrun, reset and saturation cases.
module tb_tooth_period_div;

  localparam int unsigned W   = 16;
  localparam int unsigned W8  = 8;
  localparam int          LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic         rst, cap, div_start, div_rdy, valid, ovf, overrun, dz;
  logic [W-1:0] subdiv, div_dividend, div_divider, div_result, div_rem, quot, rem;
  // 8-bit instance
  logic          rst8, cap8, div_start8, div_rdy8, valid8, ovf8, overrun8, dz8;
  logic [W8-1:0] subdiv8, div_dividend8, div_divider8, div_result8, div_rem8, quot8, rem8;

  tooth_period_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cap(cap), .subdiv(subdiv),
    .div_start(div_start), .div_dividend(div_dividend), .div_divider(div_divider),
    .div_rdy(div_rdy), .div_result(div_result), .div_rem(div_rem),
    .quot(quot), .rem(rem), .valid(valid), .ovf(ovf), .overrun(overrun), .dz(dz)
  );

  tooth_period_div #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst8), .cap(cap8), .subdiv(subdiv8),
    .div_start(div_start8), .div_dividend(div_dividend8), .div_divider(div_divider8),
    .div_rdy(div_rdy8), .div_result(div_result8), .div_rem(div_rem8),
    .quot(quot8), .rem(rem8), .valid(valid8), .ovf(ovf8), .overrun(overrun8), .dz(dz8)
  );

  // integer_div model: start low loads operands, start high runs LAT cycles.
  logic [W-1:0] m_a, m_b;
  int           m_cnt;
  always @(posedge clk) begin
    if (!div_start) begin
      m_a <= div_dividend; m_b <= div_divider; m_cnt <= 0; div_rdy <= 1'b0;
    end else if (!div_rdy) begin
      if (m_cnt == LAT - 1) begin
        div_rdy    <= 1'b1;
        div_result <= (m_b != '0) ? m_a / m_b : '1;
        div_rem    <= (m_b != '0) ? m_a % m_b : '0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  logic [W8-1:0] m8_a, m8_b;
  int            m8_cnt;
  always @(posedge clk) begin
    if (!div_start8) begin
      m8_a <= div_dividend8; m8_b <= div_divider8; m8_cnt <= 0; div_rdy8 <= 1'b0;
    end else if (!div_rdy8) begin
      if (m8_cnt == LAT - 1) begin
        div_rdy8    <= 1'b1;
        div_result8 <= (m8_b != '0) ? m8_a / m8_b : '1;
        div_rem8    <= (m8_b != '0) ? m8_a % m8_b : '0;
      end else begin
        m8_cnt <= m8_cnt + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int since   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    since++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One-clock capture strobe; returns 1 time unit after the sampling edge.
  task automatic pulse_cap(input bit sel, input logic [W-1:0] sd);
    if (sel) begin cap8 = 1'b1; subdiv8 = sd[W8-1:0]; end
    else     begin cap  = 1'b1; subdiv  = sd;         end
    @(posedge clk);
    #1;
    cap  = 1'b0;
    cap8 = 1'b0;
    since = 0;
  endtask

  // Observe n cycles: count valid pulses, capture results, first div_start high.
  task automatic window(input bit sel, input int n, output int nval,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic o, output logic d, output int ds_first);
    nval = 0; q = '0; r = '0; o = 1'b0; d = 1'b0; ds_first = -1;
    for (int i = 0; i < n; i++) begin
      if ((sel ? div_start8 : div_start) && ds_first < 0) ds_first = i;
      if (sel ? valid8 : valid) begin
        nval++;
        q = sel ? W'(quot8) : quot;
        r = sel ? W'(rem8)  : rem;
        o = sel ? ovf8 : ovf;
        d = sel ? dz8  : dz;
      end
      step();
    end
  endtask

  typedef struct {
    int         period;
    logic [W-1:0] sd;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       dz;
    int         ds;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int           nv, dsf;
    logic [W-1:0] q, r;
    logic         o, d;

    vecs[0] = '{1000, 16'd10,  16'd100, 16'd0,  1'b0,  1};
    vecs[1] = '{1003, 16'd7,   16'd143, 16'd2,  1'b0,  1};
    vecs[2] = '{50,   16'd3,   16'd16,  16'd2,  1'b0,  1};
    vecs[3] = '{13,   16'd13,  16'd1,   16'd0,  1'b0,  1};
    vecs[4] = '{20,   16'd40,  16'd0,   16'd20, 1'b0,  1};
    vecs[5] = '{100,  16'd0,   16'hFFFF,16'd0,  1'b1, -1};
    vecs[6] = '{777,  16'd1,   16'd777, 16'd0,  1'b0,  1};

    rst = 1'b0; rst8 = 1'b0; cap = 1'b0; cap8 = 1'b0; subdiv = '0; subdiv8 = '0;
    #1;
    idle(3);
    check("rst_quot",   32'(quot),  0);
    check("rst_rem",    32'(rem),   0);
    check("rst_valid",  32'(valid), 0);
    check("rst_ovf",    32'(ovf),   0);
    check("rst_start",  32'(div_start), 0);
    check("rst_dvd",    32'(div_dividend), 0);
    check("rst_dvr",    32'(div_divider), 0);
    check("rst8_quot",  32'(quot8), 0);
    rst = 1'b1; rst8 = 1'b1;
    idle(5);

    // First capture only arms the measurement.
    pulse_cap(1'b0, 16'd10);
    window(1'b0, 12, nv, q, r, o, d, dsf);
    check("unarmed_valid", 32'(nv), 0);
    check("unarmed_start", 32'(dsf), 32'hFFFF_FFFF);

    for (int i = 0; i < 7; i++) begin
      idle(vecs[i].period - 1 - since);
      pulse_cap(1'b0, vecs[i].sd);
      window(1'b0, 12, nv, q, r, o, d, dsf);
      check($sformatf("v%0d_nvalid", i), 32'(nv), 1);
      check($sformatf("v%0d_quot", i),   32'(q), 32'(vecs[i].q));
      check($sformatf("v%0d_rem", i),    32'(r), 32'(vecs[i].r));
      check($sformatf("v%0d_dz", i),     32'(d), 32'(vecs[i].dz));
      check($sformatf("v%0d_ovf", i),    32'(o), 0);
      check($sformatf("v%0d_start1", i), 32'(dsf), 32'(vecs[i].ds));
    end

    // Capture 3 cycles into RUN: abort 13/5, restart with period 4, divisor 3.
    pulse_cap(1'b0, 16'd5);
    window(1'b0, 3, nv, q, r, o, d, dsf);
    check("ovr_no_old_valid", 32'(nv), 0);
    pulse_cap(1'b0, 16'd3);
    check("ovr_pulse", 32'(overrun), 1);
    window(1'b0, 12, nv, q, r, o, d, dsf);
    check("ovr_nvalid", 32'(nv), 1);
    check("ovr_quot",   32'(q), 1);
    check("ovr_rem",    32'(r), 1);
    check("ovr_cleared", 32'(overrun), 0);

    // Reset in the middle of RUN.
    pulse_cap(1'b0, 16'd4);
    window(1'b0, 3, nv, q, r, o, d, dsf);
    check("mid_pre_start", 32'(div_start), 1);
    rst = 1'b0;
    step();
    check("mid_quot",  32'(quot), 0);
    check("mid_rem",   32'(rem), 0);
    check("mid_valid", 32'(valid), 0);
    check("mid_start", 32'(div_start), 0);
    check("mid_dvd",   32'(div_dividend), 0);
    check("mid_dvr",   32'(div_divider), 0);
    check("mid_ovr",   32'(overrun), 0);
    check("mid_dz",    32'(dz), 0);
    rst = 1'b1;
    idle(5);
    pulse_cap(1'b0, 16'd4);
    window(1'b0, 12, nv, q, r, o, d, dsf);
    check("mid_disarmed_valid", 32'(nv), 0);

    // 8-bit instance: saturated 300-cycle period, then a 20-cycle period.
    pulse_cap(1'b1, 16'd4);
    idle(299);
    pulse_cap(1'b1, 16'd4);
    window(1'b1, 12, nv, q, r, o, d, dsf);
    check("sat_nvalid", 32'(nv), 1);
    check("sat_quot",   32'(q), 63);
    check("sat_rem",    32'(r), 3);
    check("sat_ovf",    32'(o), 1);
    idle(20 - 1 - since);
    pulse_cap(1'b1, 16'd4);
    window(1'b1, 12, nv, q, r, o, d, dsf);
    check("w8_nvalid", 32'(nv), 1);
    check("w8_quot",   32'(q), 5);
    check("w8_rem",    32'(r), 0);
    check("w8_ovf",    32'(o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
